// File: rtl/conv1x1_stream.sv
// Streaming 1x1 convolution: per-pixel sequential MAC with stride, fixed-point saturation and valid/ready flow.
// Define CONV1X1_STREAM_RELU_EN to clamp negative output channels to zero (fused ReLU).
module conv1x1_stream #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FRAC_BITS    = 8,
    parameter int unsigned IN_CHANNELS  = 4,
    parameter int unsigned OUT_CHANNELS = 4,
    parameter int unsigned IN_HEIGHT    = 4,
    parameter int unsigned IN_WIDTH     = 4,
    parameter int unsigned STRIDE       = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [OUT_CHANNELS*IN_CHANNELS*DATA_WIDTH-1:0] weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]          bias_flat,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [IN_CHANNELS*DATA_WIDTH-1:0]           in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OUT_CHANNELS*DATA_WIDTH-1:0]          out_data,
    output logic                                        out_last
);
    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned PW       = 2 * DATA_WIDTH;
    localparam int unsigned AW       = PW + $clog2(IN_CHANNELS) + 1;
    localparam int unsigned ICW      = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int unsigned RW       = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int unsigned CW       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned LAST_ROW = ((IN_HEIGHT - 1) / STRIDE) * STRIDE;
    localparam int unsigned LAST_COL = ((IN_WIDTH - 1) / STRIDE) * STRIDE;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                          state_q;
    logic [RW-1:0]                   row_q;
    logic [CW-1:0]                   col_q;
    logic [ICW-1:0]                  ic_q;
    logic [IN_CHANNELS*DW-1:0]       pix_q;
    logic                            last_q;
    logic signed [AW-1:0]            acc_q [OUT_CHANNELS];
    logic                            in_ready_q;
    logic                            out_valid_q;
    logic                            out_last_q;
    logic [OUT_CHANNELS*DW-1:0]      out_data_q;

    logic signed [PW-1:0]            prod_d  [OUT_CHANNELS];
    logic signed [AW-1:0]            acc_d   [OUT_CHANNELS];
    logic signed [AW-1:0]            shift_d [OUT_CHANNELS];
    logic [OUT_CHANNELS*DW-1:0]      res_d;
    logic                            accept;
    logic                            kept;
    logic                            is_last;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    // in_ready_q is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept  = in_valid && in_ready_q;
    assign kept    = ((32'(row_q) % STRIDE) == 32'd0) && ((32'(col_q) % STRIDE) == 32'd0);
    assign is_last = (32'(row_q) == LAST_ROW) && (32'(col_q) == LAST_COL);

    // One input channel per cycle across all filters, then rounding toward -inf and saturation.
    always_comb begin
        res_d = '0;
        for (int oc = 0; oc < OUT_CHANNELS; oc++) begin
            prod_d[oc]  = PW'($signed(pix_q[32'(ic_q)*DW +: DW]))
                        * PW'($signed(weights_flat[(oc*IN_CHANNELS + 32'(ic_q))*DW +: DW]));
            acc_d[oc]   = acc_q[oc] + AW'(prod_d[oc]);
            shift_d[oc] = acc_d[oc] >>> FRAC_BITS;
            if (shift_d[oc] > SAT_MAX) begin
                res_d[oc*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
            end else if (shift_d[oc] < SAT_MIN) begin
                res_d[oc*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
            end else begin
                res_d[oc*DW +: DW] = shift_d[oc][DW-1:0];
            end
`ifdef CONV1X1_STREAM_RELU_EN
            if (shift_d[oc][AW-1]) begin
                res_d[oc*DW +: DW] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            ic_q        <= '0;
            pix_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int oc = 0; oc < OUT_CHANNELS; oc++) begin
                acc_q[oc] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (col_q == CW'(IN_WIDTH - 1)) begin
                            col_q <= '0;
                            row_q <= (row_q == RW'(IN_HEIGHT - 1)) ? '0 : row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (kept) begin
                            pix_q      <= in_data;
                            last_q     <= is_last;
                            ic_q       <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_MAC;
                            for (int oc = 0; oc < OUT_CHANNELS; oc++) begin
                                acc_q[oc] <= AW'($signed(bias_flat[oc*DW +: DW])) <<< FRAC_BITS;
                            end
                        end
                    end
                end
                S_MAC: begin
                    for (int oc = 0; oc < OUT_CHANNELS; oc++) begin
                        acc_q[oc] <= acc_d[oc];
                    end
                    if (ic_q == ICW'(IN_CHANNELS - 1)) begin
                        out_data_q  <= res_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_q;
                        state_q     <= S_OUT;
                    end else begin
                        ic_q <= ic_q + ICW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1x1_stream.sv
// Self-checking bench: default 16b/Q8 4x4-channel instance plus a 32b integer stride-2 instance.
module tb_conv1x1_stream;
    localparam int unsigned DW = 16;
    localparam int unsigned NI = 4;
    localparam int unsigned NO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NO*NI*DW-1:0] w_a;
    logic [NO*DW-1:0]    b_a;
    logic                iv_a, ir_a, ov_a, ordy_a, ol_a;
    logic [NI*DW-1:0]    id_a;
    logic [NO*DW-1:0]    od_a;

    logic [31:0] w_b, b_b, id_b, od_b;
    logic        iv_b, ir_b, ov_b, ordy_b, ol_b;

    int checks = 0;
    int errors = 0;
    int pos_a  = 0;
    logic [32:0] q_b [$];
    int s2_exp [4] = '{1, 5, 17, 21};

    typedef struct {
        logic [63:0] px;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [5];

    conv1x1_stream u_a (
        .clk(clk), .rst(rst), .weights_flat(w_a), .bias_flat(b_a),
        .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
        .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a), .out_last(ol_a)
    );

    conv1x1_stream #(
        .DATA_WIDTH(32), .FRAC_BITS(0), .IN_CHANNELS(1), .OUT_CHANNELS(1),
        .IN_HEIGHT(4), .IN_WIDTH(4), .STRIDE(2)
    ) u_b (
        .clk(clk), .rst(rst), .weights_flat(w_b), .bias_flat(b_b),
        .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
        .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b), .out_last(ol_b)
    );

    always @(posedge clk) begin
        if (ov_b && ordy_b) q_b.push_back({ol_b, od_b});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real-valued 1x1 conv in integer arithmetic, floor to integer grid, clamp.
    function automatic logic [63:0] model_a(input logic [63:0] px, input logic [255:0] w, input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int oc = 0; oc < 4; oc++) begin
            longint s;
            s = longint'($signed(b[oc*16 +: 16])) * 256;
            for (int ic = 0; ic < 4; ic++) begin
                s += longint'($signed(px[ic*16 +: 16])) * longint'($signed(w[(oc*4 + ic)*16 +: 16]));
            end
            s = s >>> 8;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`ifdef CONV1X1_STREAM_RELU_EN
            if (s < 0) s = 0;
`endif
            r[oc*16 +: 16] = 16'(s);
        end
        return r;
    endfunction

    function automatic logic [63:0] relu_exp(input logic [63:0] v);
        logic [63:0] r;
        r = v;
`ifdef CONV1X1_STREAM_RELU_EN
        for (int oc = 0; oc < 4; oc++) begin
            if (v[oc*16 + 15]) r[oc*16 +: 16] = 16'h0000;
        end
`endif
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [31:0] r;
        r = $urandom;
        if (r[16]) return {{6{r[9]}}, r[9:0]};
        return r[15:0];
    endfunction

    // Offers one pixel, then waits for its result; returns with out_valid visible.
    task automatic xact_a(input logic [63:0] px, input string nm, output logic [63:0] d, output logic l, output int wt);
        int n;
        int lat;
        iv_a = 1'b1;
        id_a = px;
        n = 0;
        while (!ir_a && n < 50) begin @(posedge clk); #1; n++; end
        wt = n;
        if (!ir_a) begin
            checks++; errors++;
            $display("FAIL %s_accept: in_ready=0 required 1", nm);
        end
        @(posedge clk); #1;
        iv_a = 1'b0;
        id_a = {rnd16(), rnd16(), rnd16(), rnd16()};
        lat = 0;
        while (!ov_a && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({nm, "_lat"}, 128'(lat), 128'(NI));
        d = od_a;
        l = ol_a;
    endtask

    task automatic run_a(input string nm, input logic [63:0] px, input logic [63:0] exp, input logic chk_wait);
        logic [63:0] d;
        logic l;
        int wt;
        xact_a(px, nm, d, l, wt);
        chk({nm, "_data"}, 128'(d), 128'(exp));
        chk({nm, "_last"}, 128'(l), 128'(pos_a == 15));
        pos_a = (pos_a + 1) % 16;
        if (chk_wait) chk({nm, "_wait"}, 128'(wt), 128'(1));
    endtask

    initial begin
        logic [63:0] px, exp, d;
        logic l, l_exp;
        int n, wt;

        rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; ordy_a = 1'b1; ordy_b = 1'b1;
        id_a = '0; id_b = '0; w_b = 32'd2; b_b = 32'd1;
        w_a = '0;
        w_a[(0*4+0)*16 +: 16] = 16'h0100;
        w_a[(0*4+1)*16 +: 16] = 16'h0080;
        w_a[(1*4+0)*16 +: 16] = 16'hFF00;
        w_a[(1*4+1)*16 +: 16] = 16'h0200;
        w_a[(2*4+0)*16 +: 16] = 16'h7FFF;
        w_a[(3*4+3)*16 +: 16] = 16'hFF00;
        b_a = 64'h0000_0000_0000_0040;

        tbl[0] = '{px: 64'h0000_0000_0400_0200, exp: 64'h0000_7FFF_0600_0440};
        tbl[1] = '{px: 64'h8000_0000_0000_7FFF, exp: 64'h7FFF_7FFF_8001_7FFF};
        tbl[2] = '{px: 64'h0100_0000_0000_8000, exp: 64'hFF00_8000_7FFF_8040};
        tbl[3] = '{px: 64'h0000_0000_0000_FFFF, exp: 64'h0000_FF80_0001_003F};
        tbl[4] = '{px: 64'h0000_0000_0001_0001, exp: 64'h0000_007F_0001_0041};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 128'({ov_a, ir_a, ol_a, od_a, ov_b, ir_b, ol_b, od_b}), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 128'({ir_a, ir_b}), 128'(2'b11));

        // Stride 2, integer: only even row/even col pixels produce outputs.
        for (int p = 0; p < 16; p++) begin
            iv_b = 1'b1;
            id_b = 32'(p);
            n = 0;
            while (!ir_b && n < 50) begin @(posedge clk); #1; n++; end
            if (p >= 5 && p <= 7) chk($sformatf("s2_backtoback_%0d", p), 128'(n), 128'(0));
            @(posedge clk); #1;
            if (p == 7) chk("s2_drop_no_out", 128'(q_b.size()), 128'(2));
        end
        iv_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("s2_count", 128'(q_b.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < q_b.size()) chk($sformatf("s2_out%0d", i), 128'(q_b[i]), 128'({i == 3, 32'(s2_exp[i])}));
        end

        for (int i = 0; i < 5; i++) begin
            run_a($sformatf("vec%0d", i), tbl[i].px, relu_exp(tbl[i].exp), i != 0);
        end

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                for (int k = 0; k < 16; k++) w_a[k*16 +: 16] = rnd16();
                for (int k = 0; k < 4; k++) b_a[k*16 +: 16] = rnd16();
            end
            px = {rnd16(), rnd16(), rnd16(), rnd16()};
            run_a($sformatf("rnd%0d", i), px, model_a(px, w_a, b_a), 1'b1);
        end

        // Backpressure: output held for 10 cycles, input ignored meanwhile.
        @(posedge clk); #1;
        px = {rnd16(), rnd16(), rnd16(), rnd16()};
        exp = model_a(px, w_a, b_a);
        ordy_a = 1'b0;
        xact_a(px, "bp", d, l, wt);
        l_exp = (pos_a == 15);
        pos_a = (pos_a + 1) % 16;
        chk("bp_data", 128'(d), 128'(exp));
        chk("bp_last", 128'(l), 128'(l_exp));
        for (int k = 0; k < 10; k++) begin
            iv_a = 1'b1;
            id_a = {rnd16(), rnd16(), rnd16(), rnd16()};
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", k), 128'({ov_a, ol_a, ir_a, od_a}), 128'({1'b1, l_exp, 1'b0, exp}));
        end
        iv_a = 1'b0;
        ordy_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 128'({ir_a, ov_a}), 128'(2'b10));
        px = {rnd16(), rnd16(), rnd16(), rnd16()};
        run_a("post_bp", px, model_a(px, w_a, b_a), 1'b0);

        // Reset during MAC.
        @(posedge clk); #1;
        iv_a = 1'b1;
        id_a = {rnd16(), rnd16(), rnd16(), rnd16()};
        n = 0;
        while (!ir_a && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        iv_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mac", 128'({ov_a, ir_a, ol_a, od_a}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mac_ready_low", 128'(ir_a), 128'(0));
        @(posedge clk); #1;
        chk("rst_mac_ready", 128'(ir_a), 128'(1));

        // Reset while output is stalled.
        ordy_a = 1'b0;
        xact_a({rnd16(), rnd16(), rnd16(), rnd16()}, "rst_st", d, l, wt);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out", 128'({ov_a, ir_a, ol_a, od_a}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        ordy_a = 1'b1;
        @(posedge clk); #1;
        pos_a = 0;

        for (int i = 0; i < 16; i++) begin
            px = {rnd16(), rnd16(), rnd16(), rnd16()};
            run_a($sformatf("frm%0d", i), px, model_a(px, w_a, b_a), i != 0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("frm_idle", 128'({ov_a, ir_a}), 128'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
